// File: rtl/comparator_pkg.sv
// comparator_pkg -- shared types and golden model for the comparator BIST.
//   state_t    : BIST controller states.
//   cmp_expect : reference magnitude compare, returns {lt,eq,gt}.
//   WIDTH_DEF  : default operand width; MAX_W is the widest supported operand.
`timescale 1ns/1ps
package comparator_pkg;
  localparam int WIDTH_DEF = 2;
  localparam int MAX_W     = 8;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FIN} state_t;

  // Operands are zero-extended to MAX_W by the caller, so one function
  // covers every supported WIDTH.
  function automatic logic [2:0] cmp_expect(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b);
    return {a < b, a == b, a > b};
  endfunction
endpackage

// File: rtl/comparator_bist_ctr.sv
// comparator_bist_ctr -- vector index and settle counters for the BIST.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   idx_clr      : restart the sweep at vector 0
//   idx_inc      : advance to the next vector
//   set_clr      : zero the settle counter
//   set_inc      : count one settle cycle
//   idx          : current vector {a,b}
//   last         : idx is the final vector (all ones)
//   settle_done  : this settle cycle is the last one
`timescale 1ns/1ps
module comparator_bist_ctr
  import comparator_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               idx_clr,
  input  logic               idx_inc,
  input  logic               set_clr,
  input  logic               set_inc,
  output logic [2*WIDTH-1:0] idx,
  output logic               last,
  output logic               settle_done
);
  // With SETTLE_CYCLES=0 the SETTLE state is never entered; clamp keeps the
  // terminal value legal.
  localparam logic [3:0] SET_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [3:0] set_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      set_cnt <= '0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + (2*WIDTH)'(1);
      if (set_clr)      set_cnt <= '0;
      else if (set_inc) set_cnt <= set_cnt + 4'd1;
    end
  end

  // Terminal vector is detected directly, so idx never wraps.
  assign last        = &idx;
  assign settle_done = (set_cnt == SET_LAST);
endmodule

// File: rtl/comparator_bist.sv
// comparator_bist -- exhaustive self-test of a magnitude comparator.
// Sweeps {a,b} over all 2^(2*WIDTH) vectors, checks lt/eq/gt against the
// golden compare, and reports pass / mismatch count / first failing vector.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : one-cycle sweep request (honoured only in IDLE)
//   a, b        : operands driven to the comparator
//   lt, eq, gt  : comparator responses
//   busy, done  : sweep running / sweep finished (held until next start)
//   pass        : zero mismatches (valid with done)
//   err_count   : number of mismatching vectors
//   first_fail  : {a,b} of the first mismatch, 0 if none
// Build option: COMPARATOR_BIST_STOP_ON_FAIL_EN ends the sweep at the first
// mismatch, leaving a,b on the failing vector.
`timescale 1ns/1ps
module comparator_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic               lt,
  input  logic               eq,
  input  logic               gt,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] first_fail
);
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] idx;
  logic               last, settle_done;
  logic               idx_clr, idx_inc, set_clr, set_inc;
  logic [2:0]         expect_v;
  logic               mismatch;

  comparator_bist_ctr #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES)) u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_clr     (idx_clr),
    .idx_inc     (idx_inc),
    .set_clr     (set_clr),
    .set_inc     (set_inc),
    .idx         (idx),
    .last        (last),
    .settle_done (settle_done)
  );

  // Any differing bit counts, so non-one-hot responses are caught too.
  assign expect_v = cmp_expect(MAX_W'(a), MAX_W'(b));
  assign mismatch = ({lt, eq, gt} != expect_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    set_clr   = 1'b0;
    set_inc   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = DRIVE;
        idx_clr   = 1'b1;
      end
      DRIVE: begin
        set_clr   = 1'b1;
        state_nxt = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        set_inc = 1'b1;
        if (settle_done) state_nxt = CHECK;
      end
      CHECK: begin
        if ((STOP_ON_FAIL && mismatch) || last) state_nxt = FIN;
        else begin
          idx_inc   = 1'b1;
          state_nxt = DRIVE;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy       <= 1'b1;
          done       <= 1'b0;
          pass       <= 1'b0;
          err_count  <= '0;
          first_fail <= '0;
        end
        DRIVE: {a, b} <= idx;
        CHECK: if (mismatch) begin
          err_count <= err_count + (2*WIDTH+1)'(1);
          if (err_count == '0) first_fail <= {a, b};
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_bist.sv
`timescale 1ns/1ps
module tb_comparator_bist;
  import comparator_pkg::*;

  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a, b;
  logic           lt, eq, gt;
  logic           busy, done, pass;
  logic [2*W:0]   err_count;
  logic [2*W-1:0] first_fail;

  int checks = 0;
  int errors = 0;
  int fault  = 0;   // 0 good, 1 eq stuck-at-0, 2 non-one-hot at {a,b}=0110

  always #5 clk = ~clk;

  comparator_bist #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .lt(lt), .eq(eq), .gt(gt), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail)
  );

  // Comparator under test, with optional planted faults.
  always_comb begin
    {lt, eq, gt} = cmp_expect(MAX_W'(a), MAX_W'(b));
    if (fault == 1) eq = 1'b0;
    if (fault == 2 && {a, b} == 4'b0110) begin
      lt = 1'b1;
      gt = 1'b1;
    end
  end

  // Start pulse seen by exactly one rising edge (edge 0).
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts rising edges after edge 0 until done, bounded.
  task automatic wait_done(output int cyc, input bit poke_busy);
    cyc = 0;
    while (!done && cyc < 300) begin
      start = poke_busy && (cyc == 10 || cyc == 20);
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a !== 0 || b !== 0) begin errors++; $display("FAIL reset_ab got %0d/%0d want 0/0", a, b); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (err_count !== 0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    checks++; if (first_fail !== 0) begin errors++; $display("FAIL reset_ff got %0d want 0", first_fail); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_good();
    int cyc;
    fault = 0;
    pulse_start();
    checks++; if (busy !== 1) begin errors++; $display("FAIL good_busy got %b want 1", busy); end
    wait_done(cyc, 1'b0);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL good_latency got %0d want 49", cyc); end
    checks++; if (pass !== 1 || busy !== 0) begin errors++; $display("FAIL good_pass got pass=%b busy=%b want 1/0", pass, busy); end
    checks++; if (err_count !== 0) begin errors++; $display("FAIL good_err got %0d want 0", err_count); end
    checks++; if (first_fail !== 0) begin errors++; $display("FAIL good_ff got %0d want 0", first_fail); end
    checks++; if (a !== 3 || b !== 3) begin errors++; $display("FAIL good_last_ab got %0d/%0d want 3/3", a, b); end
  endtask

  task automatic test_stuck_eq();
    int cyc;
    fault = 1;
    pulse_start();
    wait_done(cyc, 1'b0);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL stuck_latency got %0d want 49", cyc); end
    checks++; if (err_count !== 4) begin errors++; $display("FAIL stuck_err got %0d want 4", err_count); end
    checks++; if (first_fail !== 4'b0000) begin errors++; $display("FAIL stuck_ff got %b want 0000", first_fail); end
    checks++; if (pass !== 0 || done !== 1) begin errors++; $display("FAIL stuck_pass got pass=%b done=%b want 0/1", pass, done); end
  endtask

  task automatic test_non_one_hot();
    int cyc;
    fault = 2;
    pulse_start();
    wait_done(cyc, 1'b0);
    checks++; if (err_count !== 1) begin errors++; $display("FAIL noh_err got %0d want 1", err_count); end
    checks++; if (first_fail !== 4'b0110) begin errors++; $display("FAIL noh_ff got %b want 0110", first_fail); end
    checks++; if (pass !== 0) begin errors++; $display("FAIL noh_pass got %b want 0", pass); end
  endtask

  task automatic test_start_busy();
    int cyc;
    fault = 0;
    pulse_start();
    wait_done(cyc, 1'b1);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL busy_latency got %0d want 49", cyc); end
    checks++; if (pass !== 1) begin errors++; $display("FAIL busy_pass got %b want 1", pass); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1) begin errors++; $display("FAIL done_hold got %b want 1", done); end
    pulse_start();
    checks++; if (done !== 0 || busy !== 1) begin errors++; $display("FAIL restart got done=%b busy=%b want 0/1", done, busy); end
    wait_done(cyc, 1'b0);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL restart_latency got %0d want 49", cyc); end
  endtask

  task automatic test_async_reset();
    int cyc;
    fault = 1;
    pulse_start();
    repeat (25) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a !== 0 || b !== 0) begin errors++; $display("FAIL arst_ab got %0d/%0d want 0/0", a, b); end
    checks++; if (busy !== 0 || done !== 0 || pass !== 0) begin errors++; $display("FAIL arst_flags got %b%b%b want 000", busy, done, pass); end
    checks++; if (err_count !== 0) begin errors++; $display("FAIL arst_err got %0d want 0", err_count); end
    checks++; if (first_fail !== 0) begin errors++; $display("FAIL arst_ff got %0d want 0", first_fail); end
    @(negedge clk) rst_n = 1'b1;
    fault = 0;
    pulse_start();
    wait_done(cyc, 1'b0);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL arst_latency got %0d want 49", cyc); end
    checks++; if (pass !== 1 || err_count !== 0) begin errors++; $display("FAIL arst_pass got pass=%b err=%0d want 1/0", pass, err_count); end
  endtask

`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
  task automatic test_stop_on_fail();
    int cyc;
    fault = 1;
    pulse_start();
    wait_done(cyc, 1'b0);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL stop_latency got %0d want 4", cyc); end
    checks++; if (err_count !== 1) begin errors++; $display("FAIL stop_err got %0d want 1", err_count); end
    checks++; if (a !== 0 || b !== 0) begin errors++; $display("FAIL stop_ab got %0d/%0d want 0/0", a, b); end
    checks++; if (pass !== 0 || first_fail !== 0) begin errors++; $display("FAIL stop_pass got pass=%b ff=%0d want 0/0", pass, first_fail); end
  endtask
`endif

  initial begin
    test_reset();
    test_good();
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
    test_stop_on_fail();
`else
    test_stuck_eq();
    test_non_one_hot();
    test_start_busy();
    test_async_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
